// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler: two buffered producers share the register file's single write port.
// Optional same-edge bypass into the output register when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 2,
    parameter int DW    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [AW-1:0]        a_addr,
    input  logic [DW-1:0]        a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [AW-1:0]        b_addr,
    input  logic [DW-1:0]        b_data,
    output logic [AW-1:0]        rf_wr,
    output logic [DW-1:0]        rf_wd,
    output logic                 rf_regwrite,
    output logic [(1<<AW)-1:0]   pending,
    output logic                 idle
);

    localparam int PW   = $clog2(DEPTH) + 1;
    localparam int NREG = 1 << AW;

    // Index 0 is port A, index 1 is port B throughout.
    logic [1:0]                in_valid;
    logic [1:0][AW-1:0]        in_addr;
    logic [1:0][DW-1:0]        in_data;
    logic [1:0]                ready;
    logic [1:0]                accept;
    logic [1:0]                push;
    logic [1:0]                pop;
    logic [1:0]                empty;
    logic [1:0]                full;
    logic [1:0]                grant;
    logic [1:0]                bypass;
    logic [1:0][AW-1:0]        head_addr;
    logic [1:0][DW-1:0]        head_data;
    logic [1:0][NREG-1:0]      fifo_pend;

    logic                      last_b_reg;
    logic                      last_b_next;
    logic                      we_next;
    logic [AW-1:0]             wr_next;
    logic [DW-1:0]             wd_next;

    assign in_valid = {b_valid, a_valid};
    assign in_addr  = {b_addr, a_addr};
    assign in_data  = {b_data, a_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [PW-1:0]    wptr_reg;
            logic [PW-1:0]    rptr_reg;
            logic [DEPTH-1:0] valid_reg;
            logic [DEPTH-1:0] valid_next;
            logic [NREG-1:0]  pend;
            logic [AW-1:0]    addr_mem [DEPTH];
            logic [DW-1:0]    data_mem [DEPTH];

            assign empty[gi] = (wptr_reg == rptr_reg);
            assign full[gi]  = (wptr_reg[PW-1] != rptr_reg[PW-1]) &&
                               (wptr_reg[PW-2:0] == rptr_reg[PW-2:0]);
            // Ready looks only at the registered full flag, so a pop never makes a full FIFO ready.
            assign ready[gi]  = !reset && !full[gi];
            // Writes to register 0 are accepted but never buffered.
            assign accept[gi] = in_valid[gi] && ready[gi] && (in_addr[gi] != '0);

            assign head_addr[gi] = addr_mem[rptr_reg[PW-2:0]];
            assign head_data[gi] = data_mem[rptr_reg[PW-2:0]];

            always_comb begin
                valid_next = valid_reg;
                if (pop[gi])
                    valid_next[rptr_reg[PW-2:0]] = 1'b0;
                if (push[gi])
                    valid_next[wptr_reg[PW-2:0]] = 1'b1;
            end

            always_comb begin
                pend = '0;
                for (int s = 0; s < DEPTH; s++)
                    if (valid_reg[s])
                        pend[addr_mem[s]] = 1'b1;
            end
            assign fifo_pend[gi] = pend;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    valid_reg <= '0;
                end else begin
                    if (push[gi])
                        wptr_reg <= wptr_reg + PW'(1);
                    if (pop[gi])
                        rptr_reg <= rptr_reg + PW'(1);
                    valid_reg <= valid_next;
                end
            end

            always_ff @(posedge clock) begin
                if (push[gi]) begin
                    addr_mem[wptr_reg[PW-2:0]] <= in_addr[gi];
                    data_mem[wptr_reg[PW-2:0]] <= in_data[gi];
                end
            end
        end
    endgenerate

    // Round-robin: on conflict the port that did not win last time goes first.
    always_comb begin
        grant = '0;
        if (!empty[0] && (empty[1] || last_b_reg))
            grant[0] = 1'b1;
        else if (!empty[1])
            grant[1] = 1'b1;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // No grant means both FIFOs are empty, so any accepted beat may skip its FIFO.
    always_comb begin
        bypass = '0;
        if (grant == 2'b00) begin
            if (accept[0] && (!accept[1] || last_b_reg))
                bypass[0] = 1'b1;
            else if (accept[1])
                bypass[1] = 1'b1;
        end
    end
`else
    assign bypass = '0;
`endif

    assign push = accept & ~bypass;
    assign pop  = grant;

    always_comb begin
        we_next     = 1'b0;
        wr_next     = rf_wr;
        wd_next     = rf_wd;
        last_b_next = last_b_reg;
        if (grant[0]) begin
            we_next = 1'b1; wr_next = head_addr[0]; wd_next = head_data[0]; last_b_next = 1'b0;
        end else if (grant[1]) begin
            we_next = 1'b1; wr_next = head_addr[1]; wd_next = head_data[1]; last_b_next = 1'b1;
        end else if (bypass[0]) begin
            we_next = 1'b1; wr_next = in_addr[0]; wd_next = in_data[0]; last_b_next = 1'b0;
        end else if (bypass[1]) begin
            we_next = 1'b1; wr_next = in_addr[1]; wd_next = in_data[1]; last_b_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_regwrite <= 1'b0;
            rf_wr       <= '0;
            rf_wd       <= '0;
            last_b_reg  <= 1'b1;
        end else begin
            rf_regwrite <= we_next;
            rf_wr       <= wr_next;
            rf_wd       <= wd_next;
            last_b_reg  <= last_b_next;
        end
    end

    assign a_ready = ready[0];
    assign b_ready = ready[1];

    always_comb begin
        pending = fifo_pend[0] | fifo_pend[1];
        if (rf_regwrite)
            pending[rf_wr] = 1'b1;
        pending[0] = 1'b0;
    end

    assign idle = empty[0] && empty[1] && !rf_regwrite;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-level model compared every cycle plus directed literal checks.
// Build with REGFILE_WB_BYPASS_EN defined to exercise the bypass variant.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [1:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic [1:0]  rf_wr;
    logic [15:0] rf_wd;
    logic        rf_regwrite;
    logic [3:0]  pending;
    logic        idle;

    int vecs = 0;
    int errs = 0;
    bit checking = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(2), .DW(16)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_regwrite(rf_regwrite),
        .pending(pending), .idle(idle)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: two queues, a last-winner flag and the write-port register.
    typedef struct packed { logic [1:0] addr; logic [15:0] data; } beat_t;
    beat_t       qa[$];
    beat_t       qb[$];
    bit          m_last_b;
    bit          m_we;
    logic [1:0]  m_wr;
    logic [15:0] m_wd;
    logic [17:0] wlog[$];

    always @(posedge clock or posedge reset) begin
        bit    take_a, take_b;
        beat_t w;
        if (reset) begin
            qa.delete(); qb.delete();
            m_last_b = 1; m_we = 0; m_wr = 0; m_wd = 0;
        end else begin
            take_a = a_valid && (qa.size() < DEPTH) && (a_addr != 0);
            take_b = b_valid && (qb.size() < DEPTH) && (b_addr != 0);
            m_we = 0;
            w = '0;
            if (qa.size() > 0 && (qb.size() == 0 || m_last_b)) begin
                w = qa.pop_front(); m_last_b = 0; m_we = 1;
            end else if (qb.size() > 0) begin
                w = qb.pop_front(); m_last_b = 1; m_we = 1;
            end
`ifdef REGFILE_WB_BYPASS_EN
            else if (take_a && (!take_b || m_last_b)) begin
                w = {a_addr, a_data}; take_a = 0; m_last_b = 0; m_we = 1;
            end else if (take_b) begin
                w = {b_addr, b_data}; take_b = 0; m_last_b = 1; m_we = 1;
            end
`endif
            if (m_we) begin
                m_wr = w.addr; m_wd = w.data;
            end
            if (take_a) qa.push_back({a_addr, a_data});
            if (take_b) qb.push_back({b_addr, b_data});
        end
    end

    always @(negedge clock) begin
        logic [3:0] ep;
        if (checking) begin
            ep = '0;
            foreach (qa[i]) ep[qa[i].addr] = 1'b1;
            foreach (qb[i]) ep[qb[i].addr] = 1'b1;
            if (m_we) ep[m_wr] = 1'b1;
            ep[0] = 1'b0;
            chk("rf_regwrite", rf_regwrite, m_we);
            chk("rf_wr", rf_wr, m_wr);
            chk("rf_wd", rf_wd, m_wd);
            chk("pending", pending, ep);
            chk("idle", idle, (qa.size() == 0 && qb.size() == 0 && !m_we));
            chk("a_ready", a_ready, (!reset && qa.size() < DEPTH));
            chk("b_ready", b_ready, (!reset && qb.size() < DEPTH));
            if (rf_regwrite) wlog.push_back({rf_wr, rf_wd});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive n beats on each port back-to-back, honouring ready.
    task automatic stream(input int n, input logic [1:0] aa, input logic [15:0] ad0,
                          input logic [1:0] ba, input logic [15:0] bd0);
        int   ia = 0, ib = 0, guard = 0;
        logic ra, rb;
        while ((ia < n || ib < n) && guard < 100) begin
            a_valid = (ia < n); a_addr = aa; a_data = ad0 + 16'(ia);
            b_valid = (ib < n); b_addr = ba; b_data = bd0 + 16'(ib);
            @(negedge clock);
            ra = a_ready; rb = b_ready;
            tick();
            if (a_valid && ra) ia++;
            if (b_valid && rb) ib++;
            guard++;
        end
        a_valid = 0; b_valid = 0;
        if (guard >= 100) begin
            vecs++; errs++;
            $display("FAIL stream_timeout: got a=%0d b=%0d beats, want %0d each", ia, ib, n);
        end
    endtask

    initial begin
        logic [17:0] exp_w;
        reset = 0; a_valid = 0; b_valid = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        #1 reset = 1;
        checking = 1;
        repeat (2) @(posedge clock);
        #2 reset = 0;

        // Reset mid-stream with A holding two beats
        tick();
        a_valid = 1; a_addr = 1; a_data = 16'h0100;
        b_valid = 1; b_addr = 2; b_data = 16'h0200;
        repeat (3) tick();
        chk("t1_busy_before_reset", rf_regwrite, 1);
        #2 reset = 1;
        #1;
        chk("t1_regwrite_in_reset", rf_regwrite, 0);
        chk("t1_a_ready_in_reset", a_ready, 0);
        chk("t1_pending_in_reset", pending, 0);
        a_valid = 0; b_valid = 0;
        @(posedge clock);
        #2 reset = 0;
        repeat (4) begin
            @(negedge clock);
            chk("t1_no_write_after_reset", rf_regwrite, 0);
        end
        chk("t1_pending", pending, 0);
        chk("t1_idle", idle, 1);
        chk("t1_a_ready", a_ready, 1);

        // Simultaneous A and B on an idle block: A wins first
        tick();
        a_valid = 1; a_addr = 1; a_data = 16'd7;
        b_valid = 1; b_addr = 2; b_data = 16'd9;
        tick();
        a_valid = 0; b_valid = 0;
        @(negedge clock);
`ifdef REGFILE_WB_BYPASS_EN
        chk("t6_byp_we", rf_regwrite, 1);
        chk("t6_byp_wr", rf_wr, 1);
        chk("t6_byp_wd", rf_wd, 7);
`else
        chk("t6_we_n", rf_regwrite, 0);
        chk("t6_pending_n", pending, 4'b0110);
        @(negedge clock);
        chk("t6_we_a", rf_regwrite, 1);
        chk("t6_wr_a", rf_wr, 1);
        chk("t6_wd_a", rf_wd, 7);
`endif
        @(negedge clock);
        chk("t6_we_b", rf_regwrite, 1);
        chk("t6_wr_b", rf_wr, 2);
        chk("t6_wd_b", rf_wd, 9);
        @(negedge clock);
        chk("t6_done", rf_regwrite, 0);

        // Contention: strict alternation starting with A
        tick();
        wlog.delete();
        stream(4, 2'd1, 16'd1, 2'd3, 16'd11);
        repeat (10) tick();
        chk("t3_count", wlog.size(), 8);
        for (int k = 0; k < 4; k++) begin
            if (2 * k + 1 < wlog.size()) begin
                exp_w = {2'd1, 16'(k + 1)};
                chk("t3_order_a", wlog[2 * k], exp_w);
                exp_w = {2'd3, 16'(k + 11)};
                chk("t3_order_b", wlog[2 * k + 1], exp_w);
            end
        end

        // Full boundary on B, no ready-through on the popping edge
        wlog.delete();
        a_valid = 1; a_addr = 1; a_data = 16'd21;
        b_valid = 1; b_addr = 3; b_data = 16'd31;
        tick();
        a_data = 16'd22; b_data = 16'd32;
        tick();
        a_valid = 0; b_data = 16'h5555;
`ifndef REGFILE_WB_BYPASS_EN
        @(negedge clock);
        chk("t5_b_ready_full", b_ready, 0);
`endif
        tick();
        b_valid = 0;
`ifndef REGFILE_WB_BYPASS_EN
        @(negedge clock);
        chk("t5_b_ready_after_pop", b_ready, 1);
`endif
        repeat (8) tick();
`ifndef REGFILE_WB_BYPASS_EN
        chk("t5_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            exp_w = {2'd1, 16'd21}; chk("t5_w0", wlog[0], exp_w);
            exp_w = {2'd3, 16'd31}; chk("t5_w1", wlog[1], exp_w);
            exp_w = {2'd1, 16'd22}; chk("t5_w2", wlog[2], exp_w);
            exp_w = {2'd3, 16'd32}; chk("t5_w3", wlog[3], exp_w);
        end
`endif

        // Single write to r2
        a_valid = 1; a_addr = 2; a_data = 16'hBEEF;
        tick();
        a_valid = 0;
        @(negedge clock);
`ifdef REGFILE_WB_BYPASS_EN
        chk("t2_byp_we", rf_regwrite, 1);
        chk("t2_byp_wd", rf_wd, 16'hBEEF);
        chk("t2_byp_pending", pending, 4'b0100);
`else
        chk("t2_we_n", rf_regwrite, 0);
        chk("t2_pending_n", pending, 4'b0100);
        @(negedge clock);
        chk("t2_we", rf_regwrite, 1);
        chk("t2_wr", rf_wr, 2);
        chk("t2_wd", rf_wd, 16'hBEEF);
        chk("t2_pending", pending, 4'b0100);
`endif
        @(negedge clock);
        chk("t2_we_done", rf_regwrite, 0);
        chk("t2_pending_done", pending, 0);
        chk("t2_idle", idle, 1);

        // Register 0 writes are accepted and dropped
        tick();
        b_valid = 1; b_addr = 0; b_data = 16'hFFFF;
        @(negedge clock);
        chk("t4_b_ready", b_ready, 1);
        tick();
        b_valid = 0;
        repeat (3) begin
            @(negedge clock);
            chk("t4_no_write", rf_regwrite, 0);
            chk("t4_pending", pending, 0);
            chk("t4_idle", idle, 1);
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
